// File: rtl/dec_sched.sv
// Round-robin scheduler time-sharing one 8-to-256 one-hot decoder among N_REQ requesters;
// each decoded word is captured, compared against the exact one-hot value and scored.
module dec_sched #(
    parameter int N_REQ   = 4,
    parameter int DEC_LAT = 1,
    parameter int ERR_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_code,
    output logic [N_REQ-1:0]   req_ready,
    output logic [7:0]         dec_in,
    input  logic [127:0]       dec_out0,
    input  logic [127:0]       dec_out1,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [255:0]       out_word,
    output logic [2:0]         out_id,
    output logic               out_err,
    input  logic               err_clr,
    output logic [ERR_W-1:0]   err_cnt,
    output logic               busy
);
    localparam int               PTR_W    = (N_REQ > 2) ? $clog2(N_REQ) : 1;
    localparam logic [3:0]       LAT_LOAD = 4'(DEC_LAT - 1);
    localparam logic [PTR_W-1:0] PTR_RST  = PTR_W'(N_REQ - 1);

    if (N_REQ < 2 || N_REQ > 8 || DEC_LAT < 1 || DEC_LAT > 15) begin : g_param_check
        $error("dec_sched: N_REQ must be 2..8 and DEC_LAT must be 1..15");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    function automatic logic [255:0] onehot256(input logic [7:0] code);
        onehot256 = 256'd1 << code;
    endfunction

    state_t           state_r;
    state_t           state_s;
    logic [PTR_W-1:0] ptr_r;
    logic [3:0]       lat_cnt_r;
    logic             grant_found_s;
    logic [PTR_W-1:0] grant_idx_s;
    logic [7:0]       grant_code_s;
    logic [N_REQ-1:0] rv_shift_s;
    int               idx_s;
    logic             accept_s;
    logic             sample_s;
    logic [255:0]     word_s;
    logic             mis_s;

    // Round-robin search starting one past the last grant.
    always_comb begin
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
        grant_code_s  = 8'd0;
        idx_s         = 0;
        rv_shift_s    = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx_s      = (int'(ptr_r) + k) % N_REQ;
            rv_shift_s = req_valid >> idx_s;
            if (!grant_found_s && rv_shift_s[0]) begin
                grant_found_s = 1'b1;
                grant_idx_s   = PTR_W'(idx_s);
                grant_code_s  = 8'(req_code >> (8 * idx_s));
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    // Grant is offered only while idle, so a transaction never overlaps another.
    always_comb begin
        if (state_r == S_IDLE && grant_found_s) begin
            req_ready = {{(N_REQ-1){1'b0}}, 1'b1} << grant_idx_s;
        end else begin
            req_ready = '0;
        end
    end

    assign accept_s = (state_r == S_IDLE) && grant_found_s;
    assign sample_s = (state_r == S_WAIT) && (lat_cnt_r == 4'd0);
    assign word_s   = {dec_out1, dec_out0};
    assign mis_s    = (word_s != onehot256(dec_in));

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (accept_s) state_s = S_WAIT;
                else          state_s = S_IDLE;
            end
            S_WAIT: begin
                if (lat_cnt_r == 4'd0) state_s = S_HOLD;
                else                   state_s = S_WAIT;
            end
            S_HOLD: begin
                if (out_ready) state_s = S_IDLE;
                else           state_s = S_HOLD;
            end
            default: state_s = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= S_IDLE;
        else        state_r <= state_s;
    end

    // Issue on accept, capture on the sample edge, release the result on handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r     <= PTR_RST;
            lat_cnt_r <= 4'd0;
            dec_in    <= 8'd0;
            out_valid <= 1'b0;
            out_word  <= 256'd0;
            out_id    <= 3'd0;
            out_err   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            busy <= (state_s != S_IDLE);
            if (accept_s) begin
                ptr_r     <= grant_idx_s;
                dec_in    <= grant_code_s;
                out_id    <= 3'(grant_idx_s);
                lat_cnt_r <= LAT_LOAD;
            end else if (state_r == S_WAIT && lat_cnt_r != 4'd0) begin
                lat_cnt_r <= lat_cnt_r - 4'd1;
            end
            if (sample_s) begin
                out_word  <= word_s;
                out_err   <= mis_s;
                out_valid <= 1'b1;
            end else if (state_r == S_HOLD && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    // Saturating mismatch counter; a clear beats a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (err_clr) begin
            err_cnt <= '0;
        end else if (sample_s && mis_s && (err_cnt != {ERR_W{1'b1}})) begin
            err_cnt <= err_cnt + {{(ERR_W-1){1'b0}}, 1'b1};
        end
    end
endmodule

// File: tb/tb_dec_sched.sv
// Bench for dec_sched: two instances (DEC_LAT=1/ERR_W=16 and DEC_LAT=4/ERR_W=2) checked every
// cycle against a transaction-level model, plus directed literal checks.
module tb_dec_sched;
    localparam int N = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n = 1'b0;

    logic [N-1:0]   req_valid [2];
    logic [8*N-1:0] req_code  [2];
    logic [127:0]   dec_out0  [2];
    logic [127:0]   dec_out1  [2];
    logic           out_ready [2];
    logic           err_clr   [2];
    logic           kill0     [2];

    logic [N-1:0] rr0, rr1;
    logic [7:0]   di0, di1;
    logic         ov0, ov1, oe0, oe1, bz0, bz1;
    logic [255:0] ow0, ow1;
    logic [2:0]   oi0, oi1;
    logic [15:0]  ec0;
    logic [1:0]   ec1;

    dec_sched #(.N_REQ(N), .DEC_LAT(1), .ERR_W(16)) dut0 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_code(req_code[0]),
        .req_ready(rr0), .dec_in(di0), .dec_out0(dec_out0[0]), .dec_out1(dec_out1[0]),
        .out_valid(ov0), .out_ready(out_ready[0]), .out_word(ow0), .out_id(oi0),
        .out_err(oe0), .err_clr(err_clr[0]), .err_cnt(ec0), .busy(bz0));

    dec_sched #(.N_REQ(N), .DEC_LAT(4), .ERR_W(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_code(req_code[1]),
        .req_ready(rr1), .dec_in(di1), .dec_out0(dec_out0[1]), .dec_out1(dec_out1[1]),
        .out_valid(ov1), .out_ready(out_ready[1]), .out_word(ow1), .out_id(oi1),
        .out_err(oe1), .err_clr(err_clr[1]), .err_cnt(ec1), .busy(bz1));

    // Decoder stand-in: exact one-hot, optionally with the low half stuck at zero.
    always_comb begin
        {dec_out1[0], dec_out0[0]} = 256'd1 << di0;
        {dec_out1[1], dec_out0[1]} = 256'd1 << di1;
        if (kill0[0]) dec_out0[0] = 128'd0;
        if (kill0[1]) dec_out0[1] = 128'd0;
    end

    int n_cmp = 0;
    int n_err = 0;

    // Transaction-level model: edge numbers rather than a down-counter.
    int           lat  [2] = '{1, 4};
    int           cmax [2] = '{65535, 3};
    int           m_ptr [2];
    bit           m_busy [2];
    bit           m_hold [2];
    int           m_samp [2];
    logic [7:0]   m_dec [2];
    logic [2:0]   m_id [2];
    logic [255:0] m_word [2];
    bit           m_err [2];
    int           m_cnt [2];
    int           cyc = 0;
    int           glog [$];
    int           gcyc [$];

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_ptr[i] = N - 1; m_busy[i] = 1'b0; m_hold[i] = 1'b0; m_samp[i] = 0;
            m_dec[i] = 8'd0; m_id[i] = 3'd0; m_word[i] = 256'd0; m_err[i] = 1'b0; m_cnt[i] = 0;
        end
    endtask

    function automatic int pick(int i);
        for (int k = 1; k <= N; k++) begin
            if (req_valid[i][(m_ptr[i] + k) % N]) return (m_ptr[i] + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_ready(int i);
        int p;
        p = pick(i);
        if (!m_busy[i] && !m_hold[i] && p >= 0) return 4'b0001 << p;
        return 4'b0000;
    endfunction

    task automatic chk(input string nm, input int inst, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d] t=%0t got=%h want=%h", nm, inst, $time, act, exp);
        end
    endtask

    task automatic cmp_inst(input int i, input logic [N-1:0] rr, input logic [7:0] di, input logic ov,
                            input logic [255:0] ow, input logic [2:0] oi, input logic oe,
                            input logic [15:0] ec, input logic bz);
        chk("req_ready", i, rr, exp_ready(i));
        chk("dec_in", i, di, m_dec[i]);
        chk("out_valid", i, ov, m_hold[i]);
        chk("out_word", i, ow, m_word[i]);
        chk("out_id", i, oi, m_id[i]);
        chk("out_err", i, oe, m_err[i]);
        chk("err_cnt", i, ec, m_cnt[i]);
        chk("busy", i, bz, m_busy[i] || m_hold[i]);
    endtask

    // Compare process: check outputs at each falling edge, then predict the next rising edge.
    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            if (!rst_n) model_reset();
            cmp_inst(0, rr0, di0, ov0, ow0, oi0, oe0, ec0, bz0);
            cmp_inst(1, rr1, di1, ov1, ow1, oi1, oe1, {14'd0, ec1}, bz1);
            if (rst_n) begin
                if ((req_valid[0] & rr0) != 4'b0000) begin
                    for (int b = 0; b < N; b++) if (rr0[b]) glog.push_back(b);
                    gcyc.push_back(cyc);
                end
                for (int i = 0; i < 2; i++) begin
                    int  g;
                    bit  idle;
                    logic [255:0] w;
                    g    = pick(i);
                    idle = !m_busy[i] && !m_hold[i];
                    if (m_hold[i] && out_ready[i]) m_hold[i] = 1'b0;
                    if (m_busy[i] && cyc == m_samp[i]) begin
                        w = {dec_out1[i], dec_out0[i]};
                        m_word[i] = w;
                        m_err[i]  = (w != (256'd1 << m_dec[i]));
                        if (m_err[i] && m_cnt[i] < cmax[i]) m_cnt[i] = m_cnt[i] + 1;
                        m_busy[i] = 1'b0;
                        m_hold[i] = 1'b1;
                    end
                    if (err_clr[i]) m_cnt[i] = 0;
                    if (idle && g >= 0) begin
                        m_dec[i]  = req_code[i][8*g +: 8];
                        m_id[i]   = 3'(g);
                        m_ptr[i]  = g;
                        m_busy[i] = 1'b1;
                        m_samp[i] = cyc + lat[i];
                    end
                end
                cyc++;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 4'b0000; req_code[i] = 32'd0; out_ready[i] = 1'b1;
            err_clr[i] = 1'b0; kill0[i] = 1'b0;
        end
        tick(2);
        rst_n = 1'b1;
        #1;
        chk("rst_valid", 0, ov0, 1'b0);
        chk("rst_busy", 0, bz0, 1'b0);
        chk("rst_cnt", 0, ec0, 16'd0);

        // single request, code 200 on requester 2
        req_code[0]  = {8'd40, 8'd200, 8'd20, 8'd10};
        req_valid[0] = 4'b0100;
        #1;
        chk("t2_ready", 0, rr0, 4'b0100);
        tick(1);
        req_valid[0] = 4'b0000;
        tick(1);
        chk("t2_valid", 0, ov0, 1'b1);
        chk("t2_word", 0, ow0, 256'd1 << 200);
        chk("t2_id", 0, oi0, 3'd2);
        chk("t2_err", 0, oe0, 1'b0);
        tick(1);

        // reset in the middle of a transaction
        req_code[0]  = {8'd40, 8'd30, 8'd20, 8'd10};
        req_valid[0] = 4'b1111;
        tick(1);
        #2;
        rst_n = 1'b0;
        req_valid[0] = 4'b0000;
        #1;
        chk("t1_dec_in", 0, di0, 8'd0);
        chk("t1_valid", 0, ov0, 1'b0);
        chk("t1_word", 0, ow0, 256'd0);
        chk("t1_id", 0, oi0, 3'd0);
        chk("t1_busy", 0, bz0, 1'b0);
        tick(1);
        rst_n = 1'b1;
        req_valid[0] = 4'b1111;
        glog.delete();
        gcyc.delete();
        #1;
        chk("t1_first_grant", 0, rr0, 4'b0001);

        // fairness with all requesters valid
        tick(18);
        chk("t3_ngrants", 0, glog.size(), 6);
        if (glog.size() >= 6) begin
            int exp_g [6] = '{0, 1, 2, 3, 0, 1};
            for (int k = 0; k < 6; k++) chk("t3_order", k, glog[k], exp_g[k]);
            for (int k = 1; k < 6; k++) chk("t3_interval", k, gcyc[k] - gcyc[k-1], 3);
        end

        // backpressure in HOLD
        req_valid[0] = 4'b0010;
        out_ready[0] = 1'b0;
        tick(1);
        req_valid[0] = 4'b1111;
        tick(1);
        glog.delete();
        gcyc.delete();
        for (int k = 0; k < 10; k++) begin
            tick(1);
            chk("t4_valid", k, ov0, 1'b1);
            chk("t4_word", k, ow0, 256'd1 << 20);
            chk("t4_id", k, oi0, 3'd1);
            chk("t4_ready", k, rr0, 4'b0000);
        end
        chk("t4_no_accept", 0, glog.size(), 0);
        out_ready[0] = 1'b1;
        req_valid[0] = 4'b0000;
        tick(3);

        // mismatch counting and clear
        req_code[0]  = {8'd40, 8'd30, 8'd20, 8'd5};
        kill0[0]     = 1'b1;
        req_valid[0] = 4'b0001;
        tick(9);
        req_valid[0] = 4'b0000;
        chk("t5_cnt3", 0, ec0, 16'd3);
        chk("t5_err", 0, oe0, 1'b1);
        req_valid[0] = 4'b0001;
        tick(1);
        req_valid[0] = 4'b0000;
        err_clr[0]   = 1'b1;
        tick(1);
        err_clr[0] = 1'b0;
        chk("t5_clr_cnt", 0, ec0, 16'd0);
        chk("t5_clr_err", 0, oe0, 1'b1);
        chk("t5_clr_valid", 0, ov0, 1'b1);
        tick(2);
        kill0[0] = 1'b0;

        // saturation with ERR_W=2 and latency with DEC_LAT=4
        req_code[1]  = {8'd40, 8'd30, 8'd20, 8'd5};
        kill0[1]     = 1'b1;
        req_valid[1] = 4'b0001;
        tick(1);
        n = 0;
        while (ov1 !== 1'b1 && n < 20) begin
            tick(1);
            n++;
        end
        chk("t6_latency", 1, n, 4);
        tick(25);
        req_valid[1] = 4'b0000;
        chk("t6_sat", 1, ec1, 2'd3);
        tick(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
